// File: rtl/btb_pkg.sv
// Shared types for the BTB update controller: counter encoding, control states
// and the queued resolution record.
package btb_pkg;

  localparam int unsigned BTB_IDX_W = 6;
  localparam int unsigned TAG_W     = 32 - BTB_IDX_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } e_state;

  typedef enum logic {
    S_INIT,
    S_RUN
  } ctrl_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_entry_t;

  function automatic e_state sat_update(input e_state s, input logic taken);
    if (taken) return (s == ST)  ? ST  : e_state'(s + 2'd1);
    else       return (s == SNT) ? SNT : e_state'(s - 2'd1);
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of pending BTB updates; head is presented combinationally.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  upd_entry_t din_i,
  input  logic       pop_i,
  output upd_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  upd_entry_t  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB/predictor update sequencer: flags mispredictions, queues resolutions and
// drains them as read-modify-writes to the BTB, with an init sweep after reset/clear.
module btb_update_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned IDX_W = BTB_IDX_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btb_clear,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic              res_is_branch,
  input  logic [31:0]       res_pc,
  input  logic [31:0]       res_target,
  input  logic              res_taken,
  input  logic              res_pred_hit,
  input  logic [1:0]        res_pred_state,
  input  logic [31:0]       res_pred_target,
  output logic              flush_F,
  output logic [31:0]       redirect_pc,
  output logic [IDX_W-1:0]  btb_rd_idx,
  input  logic              btb_rd_valid,
  input  logic [31-IDX_W:0] btb_rd_tag,
  input  logic [1:0]        btb_rd_state,
  output logic              btb_we,
  output logic [IDX_W-1:0]  btb_wr_idx,
  output logic              btb_wr_valid,
  output logic [31-IDX_W:0] btb_wr_tag,
  output logic [1:0]        btb_wr_state,
  output logic [31:0]       btb_wr_target,
  output logic              init_busy,
  output logic [31:0]       br_count,
  output logic [31:0]       mispred_count
);

  localparam int unsigned TW = 32 - IDX_W;

  ctrl_state_e      state_q, state_d;
  logic [IDX_W:0]   sweep_q, sweep_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             wr_valid_q, wr_valid_d;
  logic [TW-1:0]    wr_tag_q, wr_tag_d;
  e_state           wr_state_q, wr_state_d;
  logic [31:0]      wr_target_q, wr_target_d;
  logic             flush_q, flush_d;
  logic [31:0]      redirect_q, redirect_d;
  logic [31:0]      br_cnt_q, br_cnt_d;
  logic [31:0]      mis_cnt_q, mis_cnt_d;

  upd_entry_t    head, din;
  logic          fifo_full, fifo_empty, push, pop;
  logic          pred_taken, mispred, fwd, eff_valid, hit;
  logic [TW-1:0] head_tag, eff_tag;
  e_state        eff_state;

  assign res_ready  = (state_q == S_RUN) && !fifo_full && !btb_clear;
  assign push       = res_valid && res_ready && res_is_branch;
  assign pop        = (state_q == S_RUN) && !fifo_empty && !btb_clear;
  assign din        = '{pc: res_pc, target: res_target, taken: res_taken};

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (btb_clear),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pred_taken = res_pred_hit && res_pred_state[1];
  assign mispred    = (res_taken != pred_taken) ||
                      (res_taken && pred_taken && (res_pred_target != res_target));

  assign btb_rd_idx = head.pc[IDX_W-1:0];
  assign head_tag   = head.pc[31:IDX_W];
  // A write still sitting on the port has not reached the array yet; use it.
  assign fwd        = we_q && (wr_idx_q == btb_rd_idx);
  assign eff_valid  = fwd ? wr_valid_q : btb_rd_valid;
  assign eff_tag    = fwd ? wr_tag_q   : btb_rd_tag;
  assign eff_state  = fwd ? wr_state_q : e_state'(btb_rd_state);
  assign hit        = eff_valid && (eff_tag == head_tag);

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    we_d        = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_valid_d  = wr_valid_q;
    wr_tag_d    = wr_tag_q;
    wr_state_d  = wr_state_q;
    wr_target_d = wr_target_q;
    flush_d     = push && mispred;
    redirect_d  = (push && mispred) ? (res_taken ? res_target : res_pc + 32'd4) : redirect_q;
    br_cnt_d    = br_cnt_q + 32'(push);
    mis_cnt_d   = mis_cnt_q + 32'(push && mispred);

    if (btb_clear) begin
      state_d = S_INIT;
      sweep_d = '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          // MSB of the sweep counter marks the whole array as written.
          if (sweep_q[IDX_W]) begin
            state_d = S_RUN;
          end else begin
            we_d        = 1'b1;
            wr_idx_d    = sweep_q[IDX_W-1:0];
            wr_valid_d  = 1'b0;
            wr_tag_d    = '0;
            wr_state_d  = WNT;
            wr_target_d = '0;
            sweep_d     = sweep_q + 1'b1;
          end
        end
        S_RUN: begin
          if (pop && (hit || head.taken)) begin
            we_d       = 1'b1;
            wr_idx_d   = btb_rd_idx;
            wr_valid_d = 1'b1;
            wr_tag_d   = head_tag;
            if (hit) begin
              wr_state_d  = sat_update(eff_state, head.taken);
              // Array target is not readable; a tag hit implies the same PC and target.
              wr_target_d = (head.taken || !fwd) ? head.target : wr_target_q;
            end else begin
              wr_state_d  = (head.target < head.pc) ? ST : WT;
              wr_target_d = head.target;
            end
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      we_q        <= 1'b0;
      wr_idx_q    <= '0;
      wr_valid_q  <= 1'b0;
      wr_tag_q    <= '0;
      wr_state_q  <= SNT;
      wr_target_q <= '0;
      flush_q     <= 1'b0;
      redirect_q  <= '0;
      br_cnt_q    <= '0;
      mis_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      we_q        <= we_d;
      wr_idx_q    <= wr_idx_d;
      wr_valid_q  <= wr_valid_d;
      wr_tag_q    <= wr_tag_d;
      wr_state_q  <= wr_state_d;
      wr_target_q <= wr_target_d;
      flush_q     <= flush_d;
      redirect_q  <= redirect_d;
      br_cnt_q    <= br_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
    end
  end

  assign flush_F       = flush_q;
  assign redirect_pc   = redirect_q;
  assign btb_we        = we_q;
  assign btb_wr_idx    = wr_idx_q;
  assign btb_wr_valid  = wr_valid_q;
  assign btb_wr_tag    = wr_tag_q;
  assign btb_wr_state  = wr_state_q;
  assign btb_wr_target = wr_target_q;
  assign init_busy     = (state_q == S_INIT);
  assign br_count      = br_cnt_q;
  assign mispred_count = mis_cnt_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: a per-index BTB model predicts every
// write and flush; a separate monitor pops and compares as the DUT presents them.
module tb_btb_update_ctrl;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 32 - IDX_W;
  localparam int unsigned N     = 1 << IDX_W;

  logic clk = 1'b0, rst_n = 1'b0, btb_clear = 1'b0;
  logic res_valid = 1'b0, res_is_branch = 1'b0, res_taken = 1'b0, res_pred_hit = 1'b0;
  logic [1:0]  res_pred_state = '0;
  logic [31:0] res_pc = '0, res_target = '0, res_pred_target = '0;
  logic res_ready, flush_F, btb_we, btb_wr_valid, init_busy;
  logic [31:0] redirect_pc, btb_wr_target, br_count, mispred_count;
  logic [IDX_W-1:0] btb_rd_idx, btb_wr_idx;
  logic btb_rd_valid;
  logic [TW-1:0] btb_rd_tag, btb_wr_tag;
  logic [1:0] btb_rd_state, btb_wr_state;

  always #5 clk = ~clk;

  btb_update_ctrl #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .btb_clear(btb_clear),
    .res_valid(res_valid), .res_ready(res_ready), .res_is_branch(res_is_branch),
    .res_pc(res_pc), .res_target(res_target), .res_taken(res_taken),
    .res_pred_hit(res_pred_hit), .res_pred_state(res_pred_state),
    .res_pred_target(res_pred_target),
    .flush_F(flush_F), .redirect_pc(redirect_pc),
    .btb_rd_idx(btb_rd_idx), .btb_rd_valid(btb_rd_valid), .btb_rd_tag(btb_rd_tag),
    .btb_rd_state(btb_rd_state),
    .btb_we(btb_we), .btb_wr_idx(btb_wr_idx), .btb_wr_valid(btb_wr_valid),
    .btb_wr_tag(btb_wr_tag), .btb_wr_state(btb_wr_state), .btb_wr_target(btb_wr_target),
    .init_busy(init_busy), .br_count(br_count), .mispred_count(mispred_count)
  );

  // BTB storage the DUT drives (asynchronous read, registered write).
  logic [N-1:0]  mem_v;
  logic [TW-1:0] mem_tag [N];
  logic [1:0]    mem_st  [N];
  always @(posedge clk) begin
    if (btb_we) begin
      mem_v[btb_wr_idx]   <= btb_wr_valid;
      mem_tag[btb_wr_idx] <= btb_wr_tag;
      mem_st[btb_wr_idx]  <= btb_wr_state;
    end
  end
  assign btb_rd_valid = mem_v[btb_rd_idx];
  assign btb_rd_tag   = mem_tag[btb_rd_idx];
  assign btb_rd_state = mem_st[btb_rd_idx];

  int unsigned errors = 0, checks = 0;
  logic [66:0] wq[$];       // {idx, valid, tag, state, target}
  logic [31:0] fq[$];       // expected redirect PCs
  logic        mv   [N];
  logic [TW-1:0] mtag [N];
  int unsigned mst  [N];
  logic [31:0] mtgt [N];
  int unsigned m_br = 0, m_mis = 0, accepted = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tgt_of(input logic [31:0] pc);
    return pc[7] ? pc - 32'h80 : pc + 32'h40;
  endfunction

  task automatic model_clear();
    wq.delete();
    for (int unsigned i = 0; i < N; i++) begin
      mv[i] = 1'b0; mtag[i] = '0; mst[i] = 1; mtgt[i] = '0;
      wq.push_back({IDX_W'(i), 1'b0, TW'(0), 2'b01, 32'h0});
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_br = 0; m_mis = 0;
    model_clear();
  endtask

  task automatic model_accept(input logic br, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic tk, input logic ph, input logic [1:0] ps,
                              input logic [31:0] pt);
    int unsigned idx, st;
    logic [TW-1:0] tg;
    logic ptk, mis;
    accepted++;
    if (!br) return;
    m_br++;
    ptk = ph && ps[1];
    mis = (tk != ptk) || (tk && ptk && (pt != tgt));
    if (mis) begin
      m_mis++;
      fq.push_back(tk ? tgt : pc + 32'd4);
    end
    idx = pc % N;
    tg  = pc[31:IDX_W];
    if (mv[idx] && mtag[idx] == tg) begin
      st = tk ? ((mst[idx] == 3) ? 3 : mst[idx] + 1) : ((mst[idx] == 0) ? 0 : mst[idx] - 1);
      mst[idx] = st;
      if (tk) mtgt[idx] = tgt;
      wq.push_back({IDX_W'(idx), 1'b1, tg, 2'(st), mtgt[idx]});
    end else if (tk) begin
      st = (tgt < pc) ? 3 : 2;
      mv[idx] = 1'b1; mtag[idx] = tg; mst[idx] = st; mtgt[idx] = tgt;
      wq.push_back({IDX_W'(idx), 1'b1, tg, 2'(st), tgt});
    end
  endtask

  // One cycle of stimulus; the model sees exactly what the DUT accepts.
  task automatic drive(input logic clr, input logic v, input logic br, input logic tk,
                       input logic ph, input logic [1:0] ps, input logic [31:0] pc,
                       input logic [31:0] pt);
    @(negedge clk); #1;
    btb_clear = clr; res_valid = v; res_is_branch = br; res_taken = tk;
    res_pred_hit = ph; res_pred_state = ps; res_pc = pc;
    res_target = tgt_of(pc); res_pred_target = pt;
    #1;
    if (clr) model_clear();
    else if (v && res_ready) model_accept(br, pc, tgt_of(pc), tk, ph, ps, pt);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic wait_ready(output int unsigned writes, output int unsigned cyc);
    writes = 0; cyc = 0;
    for (int unsigned c = 1; c <= 300; c++) begin
      drive(0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0);
      if (res_ready) begin cyc = c; break; end
      if (btb_we) writes++;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {flush_F, redirect_pc, btb_we, btb_wr_idx, btb_wr_valid, btb_wr_tag,
                 btb_wr_state, btb_wr_target, init_busy, res_ready, br_count, mispred_count},
          {1'b0, 32'h0, 1'b0, IDX_W'(0), 1'b0, TW'(0), 2'b00, 32'h0, 1'b1, 1'b0,
           32'h0, 32'h0});
  endtask

  // Monitor: every write and every flush must match the head of its queue.
  initial begin
    logic [66:0] e;
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (btb_we) begin
          if (wq.size() == 0) check("spurious_write", {btb_wr_idx, btb_wr_target}, '0);
          else begin
            e = wq.pop_front();
            check("btb_write", {btb_wr_idx, btb_wr_valid, btb_wr_tag, btb_wr_state, btb_wr_target}, e);
          end
        end
        if (flush_F) begin
          if (fq.size() == 0) check("spurious_flush", redirect_pc, 32'hFFFF_FFFF);
          else begin
            r = fq.pop_front();
            check("redirect_pc", redirect_pc, r);
          end
        end
      end
    end
  end

  initial begin
    int unsigned w, c, burst_acc;
    logic [31:0] pc;
    model_reset();
    #12;
    check_reset_outputs("reset_values");
    @(negedge clk); #1 rst_n = 1'b1;

    wait_ready(w, c);
    check("init_writes", w, 64);
    check("init_ready_cycle", c, 65);
    check("init_busy_done", {init_busy, btb_we}, 2'b00);

    // Miss, taken, forward: WT allocation and redirect to target.
    drive(0, 1, 1, 1, 0, 2'b00, 32'h100, 32'h0);
    // Miss, not taken, no prediction: no flush, no write.
    drive(0, 1, 1, 0, 0, 2'b00, 32'h104, 32'h0);
    // Accepted non-branch is ignored.
    drive(0, 1, 0, 1, 0, 2'b00, 32'h108, 32'h0);
    idle(3);
    check("br_count_directed", br_count, 32'd2);
    check("mispred_directed", mispred_count, 32'd1);

    // Same PC: allocate WT, then two back-to-back taken hits (second one forwarded).
    drive(0, 1, 1, 1, 0, 2'b00, 32'h200, 32'h0);
    idle(3);
    drive(0, 1, 1, 1, 1, 2'b10, 32'h200, 32'h240);
    drive(0, 1, 1, 1, 1, 2'b11, 32'h200, 32'h240);
    idle(3);
    check("fwd_state_st", mem_st[0], 2'b11);

    // Sustained accepts with the read port missing: one accept per cycle.
    burst_acc = accepted;
    for (int unsigned i = 0; i < 16; i++)
      drive(0, 1, 1, 1, 0, 2'b00, 32'h1000 + 32'(i) * 32'h44, 32'h0);
    check("burst_accepts", accepted - burst_acc, 16);
    idle(4);
    check("burst_drained", wq.size(), 0);

    // Clear with entries in flight: FIFO discarded, full sweep again.
    drive(0, 1, 1, 1, 0, 2'b00, 32'h300, 32'h0);
    drive(0, 1, 1, 1, 0, 2'b00, 32'h384, 32'h0);
    drive(1, 1, 1, 1, 0, 2'b00, 32'h388, 32'h0);
    wait_ready(w, c);
    check("clear_writes", w, 64);
    check("clear_ready_cycle", c, 66);

    for (int unsigned i = 0; i < 800; i++) begin
      if (i == 400) begin
        @(negedge clk); #1 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        @(negedge clk); #1 rst_n = 1'b1;
      end
      pc = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 3)) << 2);
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
            pc, ($urandom_range(0, 3) == 0) ? tgt_of(pc) + 32'd4 : tgt_of(pc));
    end
    wait_ready(w, c);
    idle(8);
    check("final_writes_empty", wq.size(), 0);
    check("final_flush_empty", fq.size(), 0);
    check("final_br_count", br_count, m_br);
    check("final_mispred_count", mispred_count, m_mis);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
